// File: rtl/riscy_port_bridge_if.sv
// riscy_port_bridge_if: core-side and device-side signals of the port bridge.
// slave = bridge, master = core plus external device.
interface riscy_port_bridge_if #(
  parameter int WIDTH = 8
);
  logic             CPU_WR;
  logic [WIDTH-1:0] CPU_DOUT;
  logic             CPU_RD;
  logic [WIDTH-1:0] CPU_DIN;
  logic             CLR_ERR;
  logic             EXT_STB;
  logic [WIDTH-1:0] EXT_DATA;
  logic             EXT_ACK;
  logic [WIDTH-1:0] EXT_IN;
  logic             EXT_IN_VLD;
  logic             FULL;
  logic             EMPTY;
  logic             IN_RDY;
  logic             WR_ERR;
  logic             OVR;

  modport slave (
    input  CPU_WR, CPU_DOUT, CPU_RD, CLR_ERR,
    input  EXT_ACK, EXT_IN, EXT_IN_VLD,
    output CPU_DIN, EXT_STB, EXT_DATA,
    output FULL, EMPTY, IN_RDY, WR_ERR, OVR
  );

  modport master (
    output CPU_WR, CPU_DOUT, CPU_RD, CLR_ERR,
    output EXT_ACK, EXT_IN, EXT_IN_VLD,
    input  CPU_DIN, EXT_STB, EXT_DATA,
    input  FULL, EMPTY, IN_RDY, WR_ERR, OVR
  );
endinterface

// File: rtl/riscy_port_bridge.sv
// riscy_port_bridge: output FIFO with four-phase STB/ACK delivery, strobed
// input holding register, FIFO status and sticky WR_ERR/OVR flags.
// Ports: CLK, RST (async, active-low), bus (riscy_port_bridge_if.slave).
// Define IO_BRIDGE_SYNC_EN to put two-flop synchronisers on EXT_ACK and
// EXT_IN_VLD; leave it undefined only for a device clocked by CLK.
module riscy_port_bridge #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input logic               CLK,
  input logic               RST,
  riscy_port_bridge_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } st_e;

  st_e              st_q;
  st_e              st_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rp_q;
  logic [AW-1:0]    wp_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             full;
  logic             empty;
  logic             stb;
  logic             pop;
  logic             push_ok;
  logic             wr_set;
  logic             ack_s;
  logic             vld_s;
  logic             vld_q;
  logic             cap;
  logic             ovr_set;
  logic [WIDTH-1:0] din_q;
  logic             rdy_q;
  logic             werr_q;
  logic             ovr_q;

`ifdef IO_BRIDGE_SYNC_EN
  logic [1:0] ack_sy;
  logic [1:0] vld_sy;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ack_sy <= '0;
      vld_sy <= '0;
    end else begin
      ack_sy <= {ack_sy[0], bus.EXT_ACK};
      vld_sy <= {vld_sy[0], bus.EXT_IN_VLD};
    end
  end

  assign ack_s = ack_sy[1];
  assign vld_s = vld_sy[1];
`else
  assign ack_s = bus.EXT_ACK;
  assign vld_s = bus.EXT_IN_VLD;
`endif

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_ok = bus.CPU_WR && (!full || pop);
  assign wr_set  = bus.CPU_WR && full && !pop;
  assign cnt_d   = cnt_q + CW'(push_ok) - CW'(pop);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st_q <= IDLE;
    end else begin
      st_q <= st_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (!empty) st_d = REQ;
      REQ:     if (ack_s)  st_d = REL;
      REL:     if (!ack_s) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    stb = 1'b0;
    pop = 1'b0;
    unique case (st_q)
      REQ: begin
        stb = 1'b1;
        pop = ack_s;
      end
      default: begin
        stb = 1'b0;
        pop = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rp_q  <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wp_q <= wp_q + AW'(1);
      if (pop)     rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wp_q] <= bus.CPU_DOUT;
  end

  assign cap     = vld_s && !vld_q;
  assign ovr_set = cap && rdy_q && !bus.CPU_RD;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_q  <= 1'b0;
      din_q  <= '0;
      rdy_q  <= 1'b0;
      werr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      vld_q <= vld_s;
      if (cap) begin
        din_q <= bus.EXT_IN;
        rdy_q <= 1'b1;
      end else if (bus.CPU_RD) begin
        rdy_q <= 1'b0;
      end
      // Set beats clear when both land on one edge.
      werr_q <= wr_set  || (werr_q && !bus.CLR_ERR);
      ovr_q  <= ovr_set || (ovr_q  && !bus.CLR_ERR);
    end
  end

  assign bus.EXT_STB  = stb;
  assign bus.EXT_DATA = empty ? '0 : mem[rp_q];
  assign bus.CPU_DIN  = din_q;
  assign bus.FULL     = full;
  assign bus.EMPTY    = empty;
  assign bus.IN_RDY   = rdy_q;
  assign bus.WR_ERR   = werr_q;
  assign bus.OVR      = ovr_q;
endmodule

// File: tb/tb_riscy_port_bridge.sv
// tb_riscy_port_bridge: scoreboard bench for riscy_port_bridge.
// Ports: none; drives the bridge through riscy_port_bridge_if.
module tb_riscy_port_bridge;
  localparam int DEPTH = 4;
  localparam int WIDTH = 8;
`ifdef IO_BRIDGE_SYNC_EN
  localparam int L = 3;
`else
  localparam int L = 1;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  bit   dev_en = 1'b0;

  riscy_port_bridge_if #(.WIDTH(WIDTH)) bus ();

  riscy_port_bridge #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Inputs as seen by each rising edge; history is newest-first.
  logic       s_wr, s_rd, s_clr;
  logic [7:0] s_dout, s_in;
  logic [3:0] vh, ah;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s_wr <= 0; s_rd <= 0; s_clr <= 0;
      s_dout <= 0; s_in <= 0; vh <= 0; ah <= 0;
    end else begin
      s_wr   <= bus.CPU_WR;
      s_rd   <= bus.CPU_RD;
      s_clr  <= bus.CLR_ERR;
      s_dout <= bus.CPU_DOUT;
      s_in   <= bus.EXT_IN;
      vh     <= {vh[2:0], bus.EXT_IN_VLD};
      ah     <= {ah[2:0], bus.EXT_ACK};
    end
  end

  // Reference model and monitor.
  logic [7:0] exp_q[$];
  int         mcnt = 0;
  bit         stb_prev = 0;
  bit         exp_werr = 0, exp_ovr = 0, exp_rdy = 0;
  logic [7:0] exp_din = 0;
  logic [7:0] cur = 0;

  always @(negedge CLK) begin : mon
    bit pop_seen, cap, oset, wset;
    int old;
    logic [7:0] e;
    if (!RST) begin
      exp_q.delete();
      mcnt = 0; stb_prev = 0;
      exp_werr = 0; exp_ovr = 0; exp_rdy = 0; exp_din = 0;
      chk("rst_stb", 32'(bus.EXT_STB), 32'(0));
      chk("rst_data", 32'(bus.EXT_DATA), 32'(0));
      chk("rst_din", 32'(bus.CPU_DIN), 32'(0));
      chk("rst_full", 32'(bus.FULL), 32'(0));
      chk("rst_empty", 32'(bus.EMPTY), 32'(1));
      chk("rst_in_rdy", 32'(bus.IN_RDY), 32'(0));
      chk("rst_wr_err", 32'(bus.WR_ERR), 32'(0));
      chk("rst_ovr", 32'(bus.OVR), 32'(0));
    end else begin
      old = mcnt;
      pop_seen = stb_prev && !bus.EXT_STB;
      if (pop_seen)
        chk("ack_latency", 32'({ah[L-1], ah[L]}), 32'(2'b10));
      wset = 0;
      if (s_wr) begin
        if (mcnt < DEPTH || pop_seen) begin
          exp_q.push_back(s_dout);
          mcnt++;
        end else begin
          wset = 1;
        end
      end
      if (pop_seen) mcnt--;
      exp_werr = wset || (exp_werr && !s_clr);
      cap  = vh[L-1] && !vh[L];
      oset = cap && exp_rdy && !s_rd;
      if (cap) begin
        exp_din = s_in;
        exp_rdy = 1;
      end else if (s_rd) begin
        exp_rdy = 0;
      end
      exp_ovr = oset || (exp_ovr && !s_clr);
      if (!stb_prev && bus.EXT_STB) begin
        chk("stb_src", 32'(old > 0), 32'(1));
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL stb_unexpected @%0t: got strobe expected none",
                   $time);
        end else begin
          e = exp_q.pop_front();
          cur = e;
          chk("stb_data", 32'(bus.EXT_DATA), 32'(e));
        end
      end else if (bus.EXT_STB) begin
        chk("data_hold", 32'(bus.EXT_DATA), 32'(cur));
      end
      if (mcnt == 0)
        chk("data_zero", 32'(bus.EXT_DATA), 32'(0));
      chk("empty", 32'(bus.EMPTY), 32'(mcnt == 0));
      chk("full", 32'(bus.FULL), 32'(mcnt == DEPTH));
      chk("wr_err", 32'(bus.WR_ERR), 32'(exp_werr));
      chk("in_rdy", 32'(bus.IN_RDY), 32'(exp_rdy));
      chk("cpu_din", 32'(bus.CPU_DIN), 32'(exp_din));
      chk("ovr", 32'(bus.OVR), 32'(exp_ovr));
      stb_prev = bus.EXT_STB;
    end
  end

  // External device: acknowledges each strobe after a random delay.
  initial begin : dev
    int n;
    forever begin
      @(negedge CLK);
      if (RST && dev_en && bus.EXT_STB && !bus.EXT_ACK) begin
        repeat ($urandom_range(0, 2)) @(negedge CLK);
        bus.EXT_ACK = 1'b1;
        n = 0;
        while (bus.EXT_STB && n < 40) begin
          @(negedge CLK);
          n++;
        end
        vectors++;
        if (n >= 40) begin
          miscompares++;
          $display("FAIL ack_timeout @%0t: got STB=1 expected STB=0", $time);
        end
        repeat ($urandom_range(0, 2)) @(negedge CLK);
        bus.EXT_ACK = 1'b0;
      end
    end
  end

  task automatic push(input logic [7:0] b);
    @(negedge CLK);
    bus.CPU_WR   = 1'b1;
    bus.CPU_DOUT = b;
    @(negedge CLK);
    bus.CPU_WR   = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] b, input int hi);
    @(negedge CLK);
    bus.EXT_IN     = b;
    bus.EXT_IN_VLD = 1'b1;
    repeat (hi) @(negedge CLK);
    bus.EXT_IN_VLD = 1'b0;
    repeat (L + 2) @(negedge CLK);
  endtask

  task automatic one_cycle_rd();
    @(negedge CLK);
    bus.CPU_RD = 1'b1;
    @(negedge CLK);
    bus.CPU_RD = 1'b0;
  endtask

  task automatic one_cycle_clr();
    @(negedge CLK);
    bus.CLR_ERR = 1'b1;
    @(negedge CLK);
    bus.CLR_ERR = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    #1;
    while (n < 300 && (exp_q.size() != 0 || mcnt != 0 ||
                       bus.EXT_STB || bus.EXT_ACK)) begin
      @(negedge CLK);
      #1;
      n++;
    end
    vectors++;
    if (n >= 300) begin
      miscompares++;
      $display("FAIL drain_timeout @%0t: got %0d queued expected 0",
               $time, exp_q.size());
    end
    repeat (L + 2) @(negedge CLK);
  endtask

  task automatic wait_stb();
    int n = 0;
    #1;
    while (n < 20 && !bus.EXT_STB) begin
      @(negedge CLK);
      #1;
      n++;
    end
    vectors++;
    if (n >= 20) begin
      miscompares++;
      $display("FAIL stb_timeout @%0t: got STB=0 expected STB=1", $time);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog @%0t: got no finish expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bus.CPU_WR = 0; bus.CPU_DOUT = 0; bus.CPU_RD = 0; bus.CLR_ERR = 0;
    bus.EXT_ACK = 0; bus.EXT_IN = 0; bus.EXT_IN_VLD = 0;
    #1 RST = 1'b0;
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;

    // Single transfer.
    dev_en = 1'b1;
    push(8'hA5);
    wait_idle();

    // Fill, overflow, drain in order, clear.
    dev_en = 1'b0;
    for (int i = 1; i <= 5; i++) push(8'(i));
    #1;
    chk("t2_full", 32'(bus.FULL), 32'(1));
    chk("t2_wr_err", 32'(bus.WR_ERR), 32'(1));
    dev_en = 1'b1;
    wait_idle();
    one_cycle_clr();
    #1 chk("t2_clr", 32'(bus.WR_ERR), 32'(0));

    // Push into a full FIFO on the edge the handshake pops.
    dev_en = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
    wait_stb();
    @(negedge CLK);
    bus.EXT_ACK = 1'b1;
    repeat (L - 1) @(negedge CLK);
    bus.CPU_WR   = 1'b1;
    bus.CPU_DOUT = 8'h77;
    @(negedge CLK);
    bus.CPU_WR = 1'b0;
    #1;
    chk("t3_full", 32'(bus.FULL), 32'(1));
    chk("t3_wr_err", 32'(bus.WR_ERR), 32'(0));
    chk("t3_stb", 32'(bus.EXT_STB), 32'(0));
    @(negedge CLK);
    bus.EXT_ACK = 1'b0;
    dev_en = 1'b1;
    wait_idle();

    // Input capture and overrun.
    pulse(8'h3C, L + 1);
    #1 chk("t4_din", 32'(bus.CPU_DIN), 32'(8'h3C));
    pulse(8'hC3, L + 1);
    #1;
    chk("t4_ovr_din", 32'(bus.CPU_DIN), 32'(8'hC3));
    chk("t4_ovr", 32'(bus.OVR), 32'(1));
    one_cycle_rd();
    one_cycle_clr();
    #1 chk("t4_clr", 32'(bus.OVR), 32'(0));

    // Capture on the same edge as a read.
    pulse(8'h11, L + 1);
    @(negedge CLK);
    bus.EXT_IN     = 8'h22;
    bus.EXT_IN_VLD = 1'b1;
    repeat (L - 1) @(negedge CLK);
    bus.CPU_RD = 1'b1;
    @(negedge CLK);
    bus.CPU_RD = 1'b0;
    repeat (2) @(negedge CLK);
    bus.EXT_IN_VLD = 1'b0;
    #1;
    chk("t5_rdy", 32'(bus.IN_RDY), 32'(1));
    chk("t5_ovr", 32'(bus.OVR), 32'(0));
    chk("t5_din", 32'(bus.CPU_DIN), 32'(8'h22));
    one_cycle_rd();

    // Random traffic on both paths.
    dev_en = 1'b1;
    fork
      begin
        repeat (400) begin
          @(negedge CLK);
          bus.CPU_WR   = 1'($urandom_range(0, 1));
          bus.CPU_DOUT = 8'($urandom);
          bus.CLR_ERR  = ($urandom_range(0, 15) == 0);
          bus.CPU_RD   = ($urandom_range(0, 3) == 0);
        end
        @(negedge CLK);
        bus.CPU_WR = 0; bus.CLR_ERR = 0; bus.CPU_RD = 0;
      end
      begin
        repeat (40) begin
          @(negedge CLK);
          bus.EXT_IN     = 8'($urandom);
          bus.EXT_IN_VLD = 1'b1;
          repeat (L + $urandom_range(0, 2)) @(negedge CLK);
          bus.EXT_IN_VLD = 1'b0;
          repeat ($urandom_range(1, 4)) @(negedge CLK);
        end
      end
    join
    wait_idle();

    // Reset in the middle of a strobe with entries queued.
    dev_en = 1'b0;
    push(8'h21);
    push(8'h22);
    push(8'h23);
    wait_stb();
    @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("t6_stb", 32'(bus.EXT_STB), 32'(0));
    chk("t6_empty", 32'(bus.EMPTY), 32'(1));
    chk("t6_data", 32'(bus.EXT_DATA), 32'(0));
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    dev_en = 1'b1;
    repeat (20) @(negedge CLK);
    #1;
    chk("t6_post_empty", 32'(bus.EMPTY), 32'(1));
    chk("t6_post_stb", 32'(bus.EXT_STB), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
